// File: rtl/mul_int_if.sv
// mul_int_if: start/busy handshake bundle for the sequential multiplier.
//   master (requester) drives start, sgn, x, y and observes busy, done, p, ovf.
//   slave  (mul_int)   observes the request and returns status and result.
//   start  request: latch operands and begin a multiply
//   sgn    1 = operands are two's-complement signed
//   x, y   multiplicand / multiplier (DSZ bits)
//   busy   calculation in progress
//   done   one-cycle pulse when p/ovf are updated
//   p      2*DSZ-bit product, held until the next accepted start
//   ovf    product does not fit in DSZ bits
interface mul_int_if #(
  parameter int DSZ = 32
) ();
  logic             start;
  logic             sgn;
  logic [DSZ-1:0]   x;
  logic [DSZ-1:0]   y;
  logic             busy;
  logic             done;
  logic [2*DSZ-1:0] p;
  logic             ovf;

  modport master (
    output start, sgn, x, y,
    input  busy, done, p, ovf
  );

  modport slave (
    input  start, sgn, x, y,
    output busy, done, p, ovf
  );
endinterface

// File: rtl/mul_int.sv
// mul_int: sequential radix-2 shift-add multiplier, DSZ x DSZ -> 2*DSZ.
//   Signed operands are reduced to magnitudes on accept, multiplied unsigned
//   over DSZ iterations, and the sign is reapplied on the final iteration.
// Ports:
//   clk   clock, all state updates on the rising edge
//   rst   synchronous active-high reset, priority over start
//   bus   mul_int_if.slave: start/sgn/x/y in, busy/done/p/ovf out
module mul_int #(
  parameter int DSZ = 32
) (
  input  logic      clk,
  input  logic      rst,
  mul_int_if.slave  bus
);
  localparam int CW = $clog2(DSZ);
  localparam logic [DSZ-1:0]   ONE_W = 1;
  localparam logic [2*DSZ-1:0] ONE_P = 1;
  localparam logic [CW-1:0]    LAST_IT = CW'(DSZ - 1);

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [DSZ:0]     acc_q, acc_d;     // carry bit included
  logic [DSZ-1:0]   mc_q, mc_d;       // multiplicand magnitude
  logic [DSZ-1:0]   mq_q, mq_d;       // multiplier magnitude, shifts out LSB-first
  logic             neg_q, neg_d;
  logic             sgn_q, sgn_d;
  logic             done_q, done_d;
  logic [2*DSZ-1:0] p_q, p_d;
  logic             ovf_q, ovf_d;

  logic [DSZ:0]     sum;
  logic [2*DSZ-1:0] mag;
  logic [2*DSZ-1:0] p_new;
  logic [DSZ-1:0]   p_hi;

  always_comb begin
    // Partial-product add; DSZ+1 bits so the carry survives into the shift.
    sum   = acc_q + (mq_q[0] ? {1'b0, mc_q} : '0);
    // {sum, mq} >> 1, truncated to 2*DSZ bits, is the final magnitude.
    mag   = {sum, mq_q[DSZ-1:1]};
    p_new = neg_q ? (~mag + ONE_P) : mag;
    p_hi  = p_new[2*DSZ-1:DSZ];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mc_d    = mc_q;
    mq_d    = mq_q;
    neg_d   = neg_q;
    sgn_d   = sgn_q;
    done_d  = 1'b0;
    p_d     = p_q;
    ovf_d   = ovf_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_RUN;
          sgn_d   = bus.sgn;
          neg_d   = bus.sgn & (bus.x[DSZ-1] ^ bus.y[DSZ-1]);
          // Negating MIN yields MIN again, which read unsigned is 2^(DSZ-1).
          mc_d    = (bus.sgn & bus.x[DSZ-1]) ? (~bus.x + ONE_W) : bus.x;
          mq_d    = (bus.sgn & bus.y[DSZ-1]) ? (~bus.y + ONE_W) : bus.y;
          acc_d   = '0;
          cnt_d   = LAST_IT;
        end
      end
      ST_RUN: begin
        acc_d = {1'b0, sum[DSZ:1]};
        mq_d  = {sum[0], mq_q[DSZ-1:1]};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          p_d     = p_new;
          ovf_d   = sgn_q ? (p_hi != {DSZ{p_new[DSZ-1]}}) : (p_hi != '0);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      mc_q    <= '0;
      mq_q    <= '0;
      neg_q   <= 1'b0;
      sgn_q   <= 1'b0;
      done_q  <= 1'b0;
      p_q     <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mc_q    <= mc_d;
      mq_q    <= mq_d;
      neg_q   <= neg_d;
      sgn_q   <= sgn_d;
      done_q  <= done_d;
      p_q     <= p_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.busy = (state_q == ST_RUN);
  assign bus.done = done_q;
  assign bus.p    = p_q;
  assign bus.ovf  = ovf_q;
endmodule
